// File: rtl/fpu_pcx_pkg.sv
// ============================================================================
// Module   : fpu_pcx_pkg
// Brief    : Shared beat layout, request/opf constants and types for the
//            FPU PCX receive path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pcx_pkg;

    localparam int c_pcx_w   = 124;
    localparam int c_vld_bit = 123;
    localparam int c_rq_hi   = 122;
    localparam int c_rq_lo   = 118;
    localparam int c_cpu_hi  = 116;
    localparam int c_cpu_lo  = 114;
    localparam int c_thr_hi  = 113;
    localparam int c_thr_lo  = 112;
    localparam int c_rd_hi   = 108;
    localparam int c_rd_lo   = 104;
    localparam int c_opf_hi  = 79;
    localparam int c_opf_lo  = 72;
    localparam int c_rs_hi   = 63;
    localparam int c_rs_lo   = 0;

    localparam logic [4:0] c_rq_fpop1 = 5'b01010;
    localparam logic [4:0] c_rq_fpop2 = 5'b01011;

    localparam logic [7:0] c_opf_fdivs  = 8'h4d;
    localparam logic [7:0] c_opf_fdivd  = 8'h4e;
    localparam logic [7:0] c_opf_fmuls  = 8'h49;
    localparam logic [7:0] c_opf_fmuld  = 8'h4a;
    localparam logic [7:0] c_opf_fsmuld = 8'h69;

    typedef enum logic [1:0] {
        ROUTE_ADD = 2'd0,
        ROUTE_MUL = 2'd1,
        ROUTE_DIV = 2'd2
    } route_e;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_RS2 = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0]  op;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [9:0]  id;
    } fifo_entry_t;

    function automatic route_e opf_route(input logic [7:0] opf);
        case (opf)
            c_opf_fdivs, c_opf_fdivd:               return ROUTE_DIV;
            c_opf_fmuls, c_opf_fmuld, c_opf_fsmuld: return ROUTE_MUL;
            default:                                return ROUTE_ADD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_pcx_fifo.sv
// ============================================================================
// Module   : fpu_pcx_fifo
// Brief    : Synchronous FIFO of assembled FP ops; pointers carry an extra
//            MSB so full and empty are distinguishable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_pcx_fifo
    import fpu_pcx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  fifo_entry_t              i_data,
    input  logic                     i_pop,
    output fifo_entry_t              o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

    logic [c_aw:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_aw:0] r_rd_ptr_q, w_rd_ptr_d;
    fifo_entry_t   r_mem_q [DEPTH];

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q + {{c_aw{1'b0}}, i_push};
        w_rd_ptr_d = r_rd_ptr_q + {{c_aw{1'b0}}, i_pop};
        o_empty    = (r_wr_ptr_q == r_rd_ptr_q);
        o_full     = (r_wr_ptr_q[c_aw] != r_rd_ptr_q[c_aw]) &&
                     (r_wr_ptr_q[c_aw-1:0] == r_rd_ptr_q[c_aw-1:0]);
        o_free     = c_depth - (r_wr_ptr_q - r_rd_ptr_q);
        o_data     = r_mem_q[r_rd_ptr_q[c_aw-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem_q[r_wr_ptr_q[c_aw-1:0]] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_pcx_rcv.sv
// ============================================================================
// Module   : fpu_pcx_rcv
// Brief    : Assembles two-beat PCX FP-op packets, queues them and dispatches
//            in order to the add/mul/div pipes. Optional FPU_PCX_RCV_BYPASS_EN
//            lets an op skip the empty queue when its pipe is ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_pcx_rcv
    import fpu_pcx_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 1
) (
    input  logic          rclk,
    input  logic          grst,
    input  logic          pcx_fpio_data_rdy_px2,
    input  logic [123:0]  pcx_fpio_data_px2,
    output logic          fp_pcx_stall,
    input  logic          add_in_rdy,
    input  logic          mul_in_rdy,
    input  logic          div_in_rdy,
    output logic          add_in_vld,
    output logic          mul_in_vld,
    output logic          div_in_vld,
    output logic [7:0]    fpin_op,
    output logic [63:0]   fpin_rs1,
    output logic [63:0]   fpin_rs2,
    output logic [9:0]    fpin_id,
    output logic          fpin_ovf_err
);

    localparam int c_cw = $clog2(DEPTH) + 1;
    localparam logic [c_cw-1:0] c_margin = (c_cw)'(STALL_MARGIN);

    function automatic logic route_rdy(input route_e r, input logic a,
                                       input logic m, input logic d);
        case (r)
            ROUTE_MUL: return m;
            ROUTE_DIV: return d;
            default:   return a;
        endcase
    endfunction

    state_e         r_state_q, w_state_d;
    logic [7:0]     r_opf_q, w_opf_d;
    logic [63:0]    r_rs1_q, w_rs1_d;
    logic [9:0]     r_id_q, w_id_d;
    logic           r_stall_q, w_stall_d;
    logic           r_ovf_q, w_ovf_d;

    logic           w_accept, w_is_fpop, w_push_req, w_push, w_pop, w_byp;
    logic           w_full, w_empty, w_out_vld;
    logic [c_cw-1:0] w_free, w_free_d;
    fifo_entry_t    w_new, w_head, w_out;
    route_e         w_new_route, w_head_route, w_out_route;
    logic           w_unused_bits;

    assign w_unused_bits = ^{pcx_fpio_data_px2[117], pcx_fpio_data_px2[111:109],
                             pcx_fpio_data_px2[103:80], pcx_fpio_data_px2[71:64]};

    assign w_accept  = pcx_fpio_data_rdy_px2 && pcx_fpio_data_px2[c_vld_bit];
    assign w_is_fpop = (pcx_fpio_data_px2[c_rq_hi:c_rq_lo] == c_rq_fpop1) ||
                       (pcx_fpio_data_px2[c_rq_hi:c_rq_lo] == c_rq_fpop2);

    always_comb begin
        w_state_d  = r_state_q;
        w_opf_d    = r_opf_q;
        w_rs1_d    = r_rs1_q;
        w_id_d     = r_id_q;
        w_push_req = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept && w_is_fpop) begin
                    w_opf_d   = pcx_fpio_data_px2[c_opf_hi:c_opf_lo];
                    w_rs1_d   = pcx_fpio_data_px2[c_rs_hi:c_rs_lo];
                    w_id_d    = {pcx_fpio_data_px2[c_cpu_hi:c_cpu_lo],
                                 pcx_fpio_data_px2[c_thr_hi:c_thr_lo],
                                 pcx_fpio_data_px2[c_rd_hi:c_rd_lo]};
                    w_state_d = ST_WAIT_RS2;
                end
            end
            ST_WAIT_RS2: begin
                // Second beat is rs2 regardless of what its header says.
                if (w_accept) begin
                    w_push_req = 1'b1;
                    w_state_d  = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_new        = '{op: r_opf_q, rs1: r_rs1_q,
                         rs2: pcx_fpio_data_px2[c_rs_hi:c_rs_lo], id: r_id_q};
        w_new_route  = opf_route(r_opf_q);
        w_head_route = opf_route(w_head.op);
`ifdef FPU_PCX_RCV_BYPASS_EN
        w_byp = w_push_req && w_empty &&
                route_rdy(w_new_route, add_in_rdy, mul_in_rdy, div_in_rdy);
`else
        w_byp = 1'b0;
`endif
        w_out_vld   = !w_empty || w_byp;
        w_out       = w_byp ? w_new : (w_empty ? '0 : w_head);
        w_out_route = w_byp ? w_new_route : w_head_route;

        w_pop  = !w_empty && !w_byp &&
                 route_rdy(w_head_route, add_in_rdy, mul_in_rdy, div_in_rdy);
        // A same-cycle pop frees the slot, so a full queue still takes the op.
        w_push  = w_push_req && !w_byp && (!w_full || w_pop);
        w_ovf_d = w_push_req && !w_byp && w_full && !w_pop;

        w_free_d  = w_free - {{(c_cw-1){1'b0}}, w_push} + {{(c_cw-1){1'b0}}, w_pop};
        w_stall_d = (w_free_d <= c_margin);
    end

    fpu_pcx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (rclk),
        .rst     (grst),
        .i_push  (w_push),
        .i_data  (w_new),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_free  (w_free)
    );

    always_ff @(posedge rclk) begin
        if (grst) begin
            r_state_q <= ST_IDLE;
            r_opf_q   <= '0;
            r_rs1_q   <= '0;
            r_id_q    <= '0;
            r_stall_q <= 1'b0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_opf_q   <= w_opf_d;
            r_rs1_q   <= w_rs1_d;
            r_id_q    <= w_id_d;
            r_stall_q <= w_stall_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    assign add_in_vld   = w_out_vld && (w_out_route == ROUTE_ADD);
    assign mul_in_vld   = w_out_vld && (w_out_route == ROUTE_MUL);
    assign div_in_vld   = w_out_vld && (w_out_route == ROUTE_DIV);
    assign fpin_op      = w_out.op;
    assign fpin_rs1     = w_out.rs1;
    assign fpin_rs2     = w_out.rs2;
    assign fpin_id      = w_out.id;
    assign fp_pcx_stall = r_stall_q;
    assign fpin_ovf_err = r_ovf_q;

endmodule

`default_nettype wire
